// File: rtl/store_queue.sv
// In-order store queue: holds store address, mask and data from dispatch until commit,
// drains committed stores to memory in order and flags loads that may alias a pending store.
module store_queue #(
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_TAG  = 5,
    parameter int WIDTH      = 3,
    parameter int SIZE       = 2**WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [WIDTH_TAG-1:0]    i_tag,
    output logic [WIDTH-1:0]        o_tail,
    output logic                    o_full,
    output logic                    o_empty,
    input  logic                    i_weA,
    input  logic [WIDTH-1:0]        i_waddrA,
    input  logic [WIDTH_ADDR-1:0]   i_addr,
    input  logic [WIDTH_DATA/8-1:0] i_mask,
    input  logic                    i_weD,
    input  logic [WIDTH-1:0]        i_waddrD,
    input  logic [WIDTH_DATA-1:0]   i_data,
    input  logic                    i_commit,
    input  logic                    i_kill,
    input  logic [WIDTH_ADDR-1:0]   i_ld_addr,
    output logic                    o_conflict,
    output logic                    o_mem_valid,
    output logic [WIDTH_ADDR-1:0]   o_mem_addr,
    output logic [WIDTH_DATA-1:0]   o_mem_data,
    output logic [WIDTH_DATA/8-1:0] o_mem_mask,
    output logic [WIDTH_TAG-1:0]    o_mem_tag,
    input  logic                    i_mem_ready
);
    localparam int WIDTH_MASK = WIDTH_DATA / 8;

    logic [WIDTH-1:0]      r_head, r_cptr, r_tail;
    logic [WIDTH:0]        r_cnt, r_ccnt;
    logic [SIZE-1:0]       r_a, r_av, r_dv, r_c;
    logic [WIDTH_ADDR-1:0] r_addr [SIZE];
    logic [WIDTH_MASK-1:0] r_mask [SIZE];
    logic [WIDTH_DATA-1:0] r_data [SIZE];
    logic [WIDTH_TAG-1:0]  r_tag  [SIZE];

    logic            w_full, w_alloc, w_commit, w_mem_valid, w_drain, w_wr_a, w_wr_d;
    logic [WIDTH:0]  w_alloc_ext, w_commit_ext, w_drain_ext;
    logic [SIZE-1:0] w_hit;

    assign w_full      = (r_cnt == (WIDTH+1)'(SIZE));
    assign w_alloc     = i_we & ~w_full & ~i_kill;
    assign w_commit    = i_commit & ~i_kill & (r_ccnt < r_cnt);
    assign w_mem_valid = r_a[r_head] & r_c[r_head] & r_av[r_head] & r_dv[r_head];
    assign w_drain     = w_mem_valid & i_mem_ready;

    // Writes to the presented head entry are dropped so the request stays stable until accepted.
    assign w_wr_a = i_weA & r_a[i_waddrA] & ~(w_alloc & (i_waddrA == r_tail))
                  & ~(w_mem_valid & (i_waddrA == r_head));
    assign w_wr_d = i_weD & r_a[i_waddrD] & ~(w_alloc & (i_waddrD == r_tail))
                  & ~(w_mem_valid & (i_waddrD == r_head));

    assign w_alloc_ext  = {{WIDTH{1'b0}}, w_alloc};
    assign w_commit_ext = {{WIDTH{1'b0}}, w_commit};
    assign w_drain_ext  = {{WIDTH{1'b0}}, w_drain};

    assign o_full      = w_full;
    assign o_empty     = (r_cnt == '0);
    assign o_tail      = r_tail;
    assign o_mem_valid = w_mem_valid;
    assign o_mem_addr  = r_addr[r_head];
    assign o_mem_data  = r_data[r_head];
    assign o_mem_mask  = r_mask[r_head];
    assign o_mem_tag   = r_tag[r_head];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_cptr <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_ccnt <= '0;
        end else begin
            if (w_drain)
                r_head <= r_head + WIDTH'(1);
            // Kill rolls the tail back to the first uncommitted slot; a same-cycle drain still counts.
            if (i_kill) begin
                r_tail <= r_cptr;
                r_cnt  <= r_ccnt - w_drain_ext;
                r_ccnt <= r_ccnt - w_drain_ext;
            end else begin
                if (w_alloc)
                    r_tail <= r_tail + WIDTH'(1);
                if (w_commit)
                    r_cptr <= r_cptr + WIDTH'(1);
                r_cnt  <= r_cnt + w_alloc_ext - w_drain_ext;
                r_ccnt <= r_ccnt + w_commit_ext - w_drain_ext;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a  <= '0;
            r_av <= '0;
            r_dv <= '0;
            r_c  <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if ((w_drain && r_head == WIDTH'(i)) || (i_kill && !r_c[i]))
                    r_a[i] <= 1'b0;
                else if (w_alloc && r_tail == WIDTH'(i))
                    r_a[i] <= 1'b1;

                if (w_alloc && r_tail == WIDTH'(i)) begin
                    r_av[i] <= 1'b0;
                    r_dv[i] <= 1'b0;
                    r_c[i]  <= 1'b0;
                end else begin
                    if (w_wr_a && i_waddrA == WIDTH'(i))
                        r_av[i] <= 1'b1;
                    if (w_wr_d && i_waddrD == WIDTH'(i))
                        r_dv[i] <= 1'b1;
                    if (w_commit && r_cptr == WIDTH'(i))
                        r_c[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_alloc)
            r_tag[r_tail] <= i_tag;
        if (w_wr_a) begin
            r_addr[i_waddrA] <= i_addr;
            r_mask[i_waddrA] <= i_mask;
        end
        if (w_wr_d)
            r_data[i_waddrD] <= i_data;
    end

    // An allocated entry with an unknown address conservatively blocks every load.
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_hit
            assign w_hit[gi] = r_a[gi] & (~r_av[gi]
                             | (r_addr[gi][WIDTH_ADDR-1:2] == i_ld_addr[WIDTH_ADDR-1:2]));
        end
    endgenerate

    assign o_conflict = |w_hit;

endmodule

// File: tb/tb_store_queue.sv
// Randomised and directed bench for store_queue; a queue-based reference model tracks
// the stores in program order and a separate monitor checks every memory request.
module tb_store_queue;
    localparam int WA = 32, WD = 32, WT = 5, W = 3, SIZE = 8;

    logic          clk = 1'b0;
    logic          i_rst, i_we, i_weA, i_weD, i_commit, i_kill, i_mem_ready;
    logic [WT-1:0] i_tag;
    logic [W-1:0]  i_waddrA, i_waddrD;
    logic [WA-1:0] i_addr, i_ld_addr;
    logic [3:0]    i_mask;
    logic [WD-1:0] i_data;
    logic [W-1:0]  o_tail;
    logic          o_full, o_empty, o_conflict, o_mem_valid;
    logic [WA-1:0] o_mem_addr;
    logic [WD-1:0] o_mem_data;
    logic [3:0]    o_mem_mask;
    logic [WT-1:0] o_mem_tag;

    always #5 clk = ~clk;

    store_queue #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH_TAG(WT), .WIDTH(W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_we(i_we), .i_tag(i_tag), .o_tail(o_tail),
        .o_full(o_full), .o_empty(o_empty), .i_weA(i_weA), .i_waddrA(i_waddrA),
        .i_addr(i_addr), .i_mask(i_mask), .i_weD(i_weD), .i_waddrD(i_waddrD),
        .i_data(i_data), .i_commit(i_commit), .i_kill(i_kill), .i_ld_addr(i_ld_addr),
        .o_conflict(o_conflict), .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_mem_mask(o_mem_mask), .o_mem_tag(o_mem_tag),
        .i_mem_ready(i_mem_ready)
    );

    typedef struct {
        int            idx;
        logic [WT-1:0] tag;
        logic [WA-1:0] addr;
        logic [WD-1:0] data;
        logic [3:0]    mask;
        bit            av, dv, c;
    } ent_t;

    ent_t     mq[$];          // stores in program order, oldest first
    int       head_m = 0;
    int       n_cmp = 0, n_bad = 0;
    int       dut_drains = 0;
    logic [WT-1:0] last_tag = '0;
    bit       started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return mq.size() > 0 && mq[0].c && mq[0].av && mq[0].dv;
    endfunction

    function automatic int m_tail();
        return (head_m + mq.size()) % SIZE;
    endfunction

    function automatic int m_ncommitted();
        int n = 0;
        foreach (mq[k]) if (mq[k].c) n++;
        return n;
    endfunction

    function automatic bit m_conflict(input logic [WA-1:0] la);
        foreach (mq[k])
            if (!mq[k].av || mq[k].addr[WA-1:2] == la[WA-1:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Applies one clock edge to the model using the inputs presented during that cycle.
    task automatic model_edge();
        bit full, valid, drain, alloc, commit;
        ent_t e;
        if (i_rst) begin
            mq.delete();
            head_m = 0;
            return;
        end
        full   = (mq.size() == SIZE);
        valid  = m_valid();
        drain  = valid && i_mem_ready;
        alloc  = i_we && !full && !i_kill;
        commit = i_commit && !i_kill && (m_ncommitted() < mq.size());
        foreach (mq[k]) begin
            if (i_weA && mq[k].idx == int'(i_waddrA) && !(valid && k == 0)) begin
                mq[k].addr = i_addr;
                mq[k].mask = i_mask;
                mq[k].av   = 1;
            end
            if (i_weD && mq[k].idx == int'(i_waddrD) && !(valid && k == 0)) begin
                mq[k].data = i_data;
                mq[k].dv   = 1;
            end
        end
        if (commit) begin
            foreach (mq[k]) if (!mq[k].c) begin mq[k].c = 1; break; end
        end
        if (drain) begin
            void'(mq.pop_front());
            head_m = (head_m + 1) % SIZE;
        end
        if (i_kill) begin
            while (mq.size() > 0 && !mq[mq.size()-1].c) void'(mq.pop_back());
        end else if (alloc) begin
            e = '{idx: m_tail(), tag: i_tag, addr: '0, data: '0, mask: '0, av: 0, dv: 0, c: 0};
            mq.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        started = 1;
        #1;
    endtask

    task automatic idle();
        i_we = 0; i_weA = 0; i_weD = 0; i_commit = 0; i_kill = 0; i_mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1;
        step();
        i_rst = 0;
    endtask

    // Status and conflict check against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("full", o_full, mq.size() == SIZE);
            chk("empty", o_empty, mq.size() == 0);
            chk("tail", o_tail, m_tail());
            chk("conflict", o_conflict, m_conflict(i_ld_addr));
            chk("mem_valid", o_mem_valid, m_valid());
        end
    end

    // Memory-port monitor: every presented request must be the oldest store in the model.
    always @(negedge clk) begin
        if (started && o_mem_valid) begin
            if (mq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL mem_unexpected: got tag %0h expected no request", o_mem_tag);
            end else begin
                chk("mem_addr", o_mem_addr, mq[0].addr);
                chk("mem_data", o_mem_data, mq[0].data);
                chk("mem_mask", o_mem_mask, mq[0].mask);
                chk("mem_tag", o_mem_tag, mq[0].tag);
            end
            if (i_mem_ready) begin
                dut_drains++;
                last_tag = o_mem_tag;
                $display("drain tag=%0d addr=%08h data=%08h mask=%h", o_mem_tag, o_mem_addr,
                         o_mem_data, o_mem_mask);
            end
        end
    end

    initial begin
        int base;
        idle();
        i_rst = 1; i_tag = '0; i_waddrA = '0; i_waddrD = '0; i_addr = '0; i_mask = '0;
        i_data = '0; i_ld_addr = '0;
        step(); step();
        i_rst = 0;
        chk("reset_empty", o_empty, 1);
        chk("reset_tail", o_tail, 0);

        // fill to capacity, then one allocation too many
        for (int k = 1; k <= 8; k++) begin
            i_we = 1; i_tag = WT'(k); step();
        end
        chk("fill_full", o_full, 1);
        chk("fill_tail", o_tail, 0);
        chk("fill_empty", o_empty, 0);
        i_tag = 5'd9; step();
        i_we = 0;
        chk("over_tail", o_tail, 0);
        chk("over_full", o_full, 1);

        // back-pressure holds the request stable
        do_reset();
        i_we = 1; i_tag = 5'd1; step();
        i_we = 0;
        i_weA = 1; i_waddrA = 3'd0; i_addr = 32'h100; i_mask = 4'hF;
        i_weD = 1; i_waddrD = 3'd0; i_data = 32'hDEAD; step();
        i_weA = 0; i_weD = 0; i_commit = 1; step();
        i_commit = 0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", o_mem_valid, 1);
            chk("hold_addr", o_mem_addr, 32'h100);
            chk("hold_data", o_mem_data, 32'hDEAD);
            step();
        end
        i_mem_ready = 1; step();
        i_mem_ready = 0;
        chk("hold_drained_empty", o_empty, 1);

        // kill keeps the committed store and drops the younger one
        do_reset();
        i_we = 1; i_tag = 5'd2; step();
        i_tag = 5'd3; step();
        i_we = 0;
        i_weA = 1; i_waddrA = 3'd0; i_addr = 32'h400; i_mask = 4'h3;
        i_weD = 1; i_waddrD = 3'd0; i_data = 32'h1111; step();
        i_waddrA = 3'd1; i_addr = 32'h500; i_waddrD = 3'd1; i_data = 32'h2222; step();
        i_weA = 0; i_weD = 0; i_commit = 1; step();
        i_commit = 0; i_kill = 1; step();
        i_kill = 0;
        chk("kill_tail", o_tail, 1);
        chk("kill_empty", o_empty, 0);
        base = dut_drains;
        i_mem_ready = 1;
        for (int k = 0; k < 4; k++) step();
        i_mem_ready = 0;
        chk("kill_drains", dut_drains - base, 1);
        chk("kill_last_tag", last_tag, 2);
        chk("kill_final_empty", o_empty, 1);

        // conflict detection is word granular and covers unknown addresses
        do_reset();
        i_ld_addr = 32'h200;
        i_we = 1; i_tag = 5'd4; step();
        i_we = 0;
        chk("conf_noaddr", o_conflict, 1);
        i_weA = 1; i_waddrA = 3'd0; i_addr = 32'h204; i_mask = 4'hF; step();
        i_weA = 0;
        chk("conf_other_word", o_conflict, 0);
        i_ld_addr = 32'h207;
        #1 chk("conf_same_word", o_conflict, 1);
        i_ld_addr = 32'h200;
        i_weA = 1; i_addr = 32'h200; step();
        i_weA = 0;
        chk("conf_match", o_conflict, 1);
        i_weD = 1; i_waddrD = 3'd0; i_data = 32'h55; step();
        i_weD = 0; i_commit = 1; step();
        i_commit = 0; i_mem_ready = 1; step();
        i_mem_ready = 0;
        chk("conf_drained", o_conflict, 0);

        // streaming 20 stores through a wrapping ring
        do_reset();
        base = dut_drains;
        for (int c = 0; c < 24; c++) begin
            i_we = (c < 20); i_tag = WT'(c); i_commit = 1; i_mem_ready = 1;
            i_weA = (c >= 1 && c <= 20); i_weD = i_weA;
            i_waddrA = W'((c + 7) % 8); i_waddrD = i_waddrA;
            i_addr = 32'h1000 + 32'(4 * (c - 1)); i_mask = 4'($urandom); i_data = $urandom;
            step();
        end
        idle();
        chk("stream_drains", dut_drains - base, 20);
        chk("stream_empty", o_empty, 1);

        // reset with committed stores pending
        do_reset();
        for (int k = 0; k < 3; k++) begin
            i_we = 1; i_tag = WT'(10 + k); step();
        end
        i_we = 0;
        for (int k = 0; k < 3; k++) begin
            i_weA = 1; i_waddrA = W'(k); i_addr = 32'h800 + 32'(4 * k); i_mask = 4'hF;
            i_weD = 1; i_waddrD = W'(k); i_data = 32'(k + 100); step();
        end
        i_weA = 0; i_weD = 0;
        for (int k = 0; k < 3; k++) begin
            i_commit = 1; step();
        end
        i_commit = 0;
        chk("prerst_valid", o_mem_valid, 1);
        i_rst = 1; step();
        i_rst = 0;
        chk("rst_valid", o_mem_valid, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_tail", o_tail, 0);

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            i_we = ($urandom_range(0, 1) == 1); i_tag = WT'($urandom);
            i_weA = ($urandom_range(0, 1) == 1); i_waddrA = W'($urandom);
            i_addr = 32'h200 + 32'(4 * $urandom_range(0, 3)); i_mask = 4'($urandom);
            i_weD = ($urandom_range(0, 1) == 1); i_waddrD = W'($urandom); i_data = $urandom;
            i_commit = ($urandom_range(0, 9) < 4);
            i_kill = ($urandom_range(0, 39) == 0);
            i_mem_ready = ($urandom_range(0, 9) < 6);
            i_ld_addr = 32'h200 + 32'($urandom_range(0, 19));
            step();
        end
        idle();
        i_kill = 1; step();
        i_kill = 0;
        for (int k = 0; k < 40; k++) begin
            i_weA = 1; i_waddrA = W'(k % 8); i_addr = 32'h300; i_mask = 4'hF;
            i_weD = 1; i_waddrD = W'(k % 8); i_data = 32'(k);
            i_mem_ready = 1;
            step();
        end
        idle();
        chk("random_final_empty", o_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Store-side counterpart of the load address queue: an in-order ring buffer holding store address, byte mask and data from dispatch until commit.
- Committed stores drain to the data memory through a valid/ready write port.
- Provides a combinational conflict check so a load can set its store-dependency (S) state.
- Kill discards uncommitted stores on a pipeline flush.

Parameters:
- WIDTH_ADDR, 32, address width.
- WIDTH_DATA, 32, store data width.
- WIDTH_TAG, 5, ROB tag width.
- WIDTH, 3, index width.
- SIZE, 2**WIDTH, number of entries.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_we  input  1  allocate entry at tail.
- i_tag  input  WIDTH_TAG  ROB tag of the allocated store.
- o_tail  output  WIDTH  index the next allocation receives.
- o_full  output  1  no free entry.
- o_empty  output  1  no allocated entry.
- i_weA  input  1  address write.
- i_waddrA  input  WIDTH  entry index for the address write.
- i_addr  input  WIDTH_ADDR  store address.
- i_mask  input  WIDTH_DATA/8  byte enables.
- i_weD  input  1  data write.
- i_waddrD  input  WIDTH  entry index for the data write.
- i_data  input  WIDTH_DATA  store data.
- i_commit  input  1  ROB retires the oldest uncommitted store.
- i_kill  input  1  flush all uncommitted entries.
- i_ld_addr  input  WIDTH_ADDR  load address to check.
- o_conflict  output  1  load must wait.
- o_mem_valid  output  1  write request valid.
- o_mem_addr  output  WIDTH_ADDR  write request address.
- o_mem_data  output  WIDTH_DATA  write request data.
- o_mem_mask  output  WIDTH_DATA/8  write request byte enables.
- o_mem_tag  output  WIDTH_TAG  write request ROB tag.
- i_mem_ready  input  1  memory accepts the request.

Behaviour:
- State:
  - Pointers: head (oldest), cptr (oldest uncommitted), tail (next free), each WIDTH bits, wrapping SIZE-1 -> 0.
  - Occupancy counts: cnt (allocated) and ccnt (committed, not yet drained), each WIDTH+1 bits.
  - Per entry: A (allocated), AV (address valid), DV (data valid), C (committed), addr, mask, data, tag.
- Reset (i_rst high at a clock edge):
  - All pointers and counts cleared; all A, AV, DV and C cleared.
  - Output values after reset: o_empty=1, o_full=0, o_tail=0, o_mem_valid=0, o_conflict=0.
- Status: o_full = (cnt==SIZE); o_empty = (cnt==0); o_tail = tail.
- Allocate: when i_we & !o_full & !i_kill:
  - A[tail]=1; AV, DV and C of that entry cleared; tag captured.
  - tail and cnt increment.
  - i_we while full is ignored with no state change.
- Address write (i_weA) and data write (i_weD):
  - Write the field and set AV or DV at the given index, independent of each other and of allocation.
  - A write to an index with A=0 is ignored.
  - A write to the index being allocated in the same cycle is ignored (allocation wins).
- Commit: when i_commit & (ccnt < cnt):
  - C[cptr]=1; cptr and ccnt increment.
  - Otherwise the commit is ignored.
- Drain:
  - o_mem_valid = A[head] & C[head] & AV[head] & DV[head].
  - o_mem_* are driven from the head entry.
  - On o_mem_valid & i_mem_ready: A[head] cleared; head increments; cnt and ccnt decrement.
  - While the handshake is pending, o_mem_valid and all o_mem_* are held stable.
- Latency:
  - An entry written at edge N can drive o_mem_valid in cycle N+1 at the earliest.
  - One drain per cycle at most.
- Kill: i_kill at an edge:
  - tail <= cptr; cnt <= ccnt; A cleared for every uncommitted entry.
  - Committed entries are kept, and a drain in the same cycle still completes (its decrements apply).
  - i_kill has priority over i_we and i_commit in the same cycle.
- Simultaneous events:
  - Allocate+drain: cnt unchanged.
  - Commit+drain: ccnt unchanged.
  - Allocate when full + drain same cycle: the allocation is rejected, because o_full is sampled before the edge.
- Conflict check:
  - o_conflict = OR over entries of A & (!AV | addr[WIDTH_ADDR-1:2]==i_ld_addr[WIDTH_ADDR-1:2]).
  - Purely combinational; word-granular compare; includes committed, undrained entries.
- Wrap-around:
  - With SIZE=8, all pointers wrap 7 -> 0.
  - Full and empty are resolved solely by cnt.

Test Plan:
- Reset, then allocate 8 stores tags 1..8 -> o_full=1, o_tail=0, o_empty=0; a 9th i_we is ignored (cnt stays 8, o_tail stays 0).
- Allocate idx0, write addr 0x100 mask 0xF data 0xDEAD, commit, hold i_mem_ready=0 for 3 cycles -> o_mem_valid=1 with addr 0x100, data 0xDEAD stable for those 3 cycles; ready=1 -> o_empty=1 next cycle.
- Allocate idx0 and idx1; commit idx0 only; raise i_kill -> o_tail=1 and cnt=1; idx0 still drains; idx1 never appears on the mem port.
- Allocate with no address written, i_ld_addr=0x200 -> o_conflict=1; write addr 0x204 -> o_conflict=0; write addr 0x200 -> o_conflict=1; drain the entry -> o_conflict=0.
- Stream 20 stores with i_we, commit and ready all high each cycle, addr/data written the cycle after allocation -> pointers wrap; mem port order equals allocation order; no loss and no duplicates.
- Raise i_rst while 3 entries are committed and mem valid -> next cycle o_mem_valid=0, o_empty=1, o_tail=0.
